ym2149_bus_ctrl: RTL and testbench

- Bus sequencer and arbiter in front of the ym2149 PSG core.
- Two requesters share the PSG bus port:
  - host port: CPU/GPU register read and write;
  - player port: register-dump music player, writes only.
- Converts each granted request into the PSG's BDIR/BC protocol (address latch, then data write or read) and returns a one-cycle acknowledge.
- Enforces a programmable idle gap between transactions.

---
 rtl/ym2149_ctrl_pkg.sv | 35 +++
 rtl/ym2149_rr_arb.sv | 45 ++++
 rtl/ym2149_bus_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ym2149_bus_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ym2149_ctrl_pkg.sv
// rtl/ym2149_ctrl_pkg.sv - shared states, bus-mode and register constants for the ym2149 bus controller
package ym2149_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WR,
        RD,
        GAP
    } state_t;

    // {BDIR,BC} bus modes
    localparam logic [1:0] BUS_IDLE  = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;
    localparam logic [1:0] BUS_ADDR  = 2'b11;

    // PSG register numbers
    localparam logic [3:0] R_MIXER     = 4'd7;
    localparam logic [3:0] R_ENV_SHAPE = 4'd13;
    localparam logic [3:0] R_IOA       = 4'd14;
    localparam logic [3:0] R_IOB       = 4'd15;

    function automatic logic [1:0] bus_mode(input state_t s);
        logic [1:0] m;
        case (s)
            ADDR:    m = BUS_ADDR;
            WR:      m = BUS_WRITE;
            RD:      m = BUS_READ;
            default: m = BUS_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ym2149_rr_arb.sv
// rtl/ym2149_rr_arb.sv - two-way round-robin arbiter (host / player)
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req_h        : host request
//   i_req_p        : player request
//   i_en           : grant enable (arbitration only happens while enabled)
//   o_grant        : one-hot grant, bit 0 = host, bit 1 = player
//   o_last         : last winner, 0 = host, 1 = player
module ym2149_rr_arb (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_h,
    input  logic       i_req_p,
    input  logic       i_en,
    output logic [1:0] o_grant,
    output logic       o_last
);

    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            if (i_req_h && i_req_p) begin
                // the requester that did not win last time goes first
                o_grant = r_last ? 2'b01 : 2'b10;
            end else begin
                o_grant = {i_req_p, i_req_h};
            end
        end
    end

    // Reset pretends the player won last so the host is favoured first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (|o_grant) begin
            r_last <= o_grant[1];
        end
    end

    assign o_last = r_last;

endmodule

// File: rtl/ym2149_bus_ctrl.sv
// rtl/ym2149_bus_ctrl.sv - host/player arbiter and BDIR/BC sequencer in front of the ym2149 PSG
//
// Optional feature macro: YM2149_ADDR_CACHE_EN (skip the address phase when the
// granted register equals the last latched one).
//
// Ports:
//   CLK, RESET_N              : clock, asynchronous active-low reset
//   H_REQ/H_RNW/H_ADDR/H_WDATA: host request (level, held until H_ACK)
//   H_ACK, H_RDATA            : host completion pulse, read data (held until next read)
//   P_REQ/P_ADDR/P_DATA       : player write request (level, held until P_ACK)
//   P_ACK                     : player completion pulse
//   PSG_BDIR/PSG_BC/PSG_DI    : PSG bus controls and data in
//   PSG_DO                    : PSG data out
//   BUSY                      : high whenever the sequencer is not idle
module ym2149_bus_ctrl
    import ym2149_ctrl_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       H_REQ,
    input  logic       H_RNW,
    input  logic [3:0] H_ADDR,
    input  logic [7:0] H_WDATA,
    output logic       H_ACK,
    output logic [7:0] H_RDATA,
    input  logic       P_REQ,
    input  logic [3:0] P_ADDR,
    input  logic [7:0] P_DATA,
    output logic       P_ACK,
    output logic       PSG_BDIR,
    output logic       PSG_BC,
    output logic [7:0] PSG_DI,
    input  logic [7:0] PSG_DO,
    output logic       BUSY
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t     r_state, w_next;
    logic [1:0] w_grant;
    logic       w_arb_en;
    logic       w_unused_rr_last;

    // transaction fields captured at grant; r_owner 0 = host, 1 = player
    logic [3:0] r_addr,  w_addr_nx;
    logic [7:0] r_data,  w_data_nx;
    logic       r_rnw,   w_rnw_nx;
    logic       r_owner, w_owner_nx;

    logic [3:0] r_gap_cnt;
    logic       w_first_gap;
    logic       w_cache_hit;

    logic [1:0] r_bus,  w_bus;
    logic [7:0] r_di,   w_di;
    logic       r_h_ack, r_p_ack, r_busy;
    logic [7:0] r_h_rdata;

    assign w_arb_en = (r_state == IDLE);

    ym2149_rr_arb u_arb (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_req_h (H_REQ),
        .i_req_p (P_REQ),
        .i_en    (w_arb_en),
        .o_grant (w_grant),
        .o_last  (w_unused_rr_last)
    );

    always_comb begin
        w_addr_nx  = r_addr;
        w_data_nx  = r_data;
        w_rnw_nx   = r_rnw;
        w_owner_nx = r_owner;
        if (w_grant[0]) begin
            w_addr_nx  = H_ADDR;
            w_data_nx  = H_WDATA;
            w_rnw_nx   = H_RNW;
            w_owner_nx = 1'b0;
        end else if (w_grant[1]) begin
            w_addr_nx  = P_ADDR;
            w_data_nx  = P_DATA;
            w_rnw_nx   = 1'b0;
            w_owner_nx = 1'b1;
        end
    end

`ifdef YM2149_ADDR_CACHE_EN
    logic [3:0] r_cache_addr;
    logic       r_cache_vld;

    assign w_cache_hit = r_cache_vld && (w_addr_nx == r_cache_addr);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cache_addr <= 4'h0;
            r_cache_vld  <= 1'b0;
        end else if (r_state == ADDR) begin
            r_cache_addr <= r_addr;
            r_cache_vld  <= 1'b1;
        end
    end
`else
    assign w_cache_hit = 1'b0;
`endif

    // Outputs are registered from the next state so they line up with the state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (|w_grant) begin
                    if (w_cache_hit) begin
                        w_next = w_rnw_nx ? RD : WR;
                    end else begin
                        w_next = ADDR;
                    end
                end
            end
            ADDR:    w_next = r_rnw ? RD : WR;
            WR, RD:  w_next = GAP;
            GAP:     if (r_gap_cnt == 4'd0) w_next = IDLE;
            default: w_next = IDLE;
        endcase

        w_bus = bus_mode(w_next);
        w_di  = 8'h00;
        if (w_next == ADDR) begin
            w_di = {4'h0, w_addr_nx};
        end else if (w_next == WR) begin
            w_di = w_data_nx;
        end

        w_first_gap = (w_next == GAP) && (r_state != GAP);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= IDLE;
            r_addr    <= 4'h0;
            r_data    <= 8'h00;
            r_rnw     <= 1'b0;
            r_owner   <= 1'b0;
            r_gap_cnt <= 4'd0;
            r_bus     <= BUS_IDLE;
            r_di      <= 8'h00;
            r_h_ack   <= 1'b0;
            r_p_ack   <= 1'b0;
            r_h_rdata <= 8'h00;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_addr  <= w_addr_nx;
            r_data  <= w_data_nx;
            r_rnw   <= w_rnw_nx;
            r_owner <= w_owner_nx;
            if (w_first_gap) begin
                r_gap_cnt <= GAP_LOAD;
            end else if (r_gap_cnt != 4'd0) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end
            r_bus   <= w_bus;
            r_di    <= w_di;
            r_h_ack <= w_first_gap && !w_owner_nx;
            r_p_ack <= w_first_gap &&  w_owner_nx;
            if (r_state == RD) begin
                r_h_rdata <= PSG_DO;
            end
            r_busy  <= (w_next != IDLE);
        end
    end

    assign PSG_BDIR = r_bus[1];
    assign PSG_BC   = r_bus[0];
    assign PSG_DI   = r_di;
    assign H_ACK    = r_h_ack;
    assign P_ACK    = r_p_ack;
    assign H_RDATA  = r_h_rdata;
    assign BUSY     = r_busy;

endmodule

// File: tb/tb_ym2149_bus_ctrl.sv
// tb/tb_ym2149_bus_ctrl.sv - self-checking bench for ym2149_bus_ctrl
module tb_ym2149_bus_ctrl;
    import ym2149_ctrl_pkg::*;

    localparam int GAP = 3;
`ifdef YM2149_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       H_REQ = 1'b0;
    logic       H_RNW = 1'b0;
    logic [3:0] H_ADDR = 4'h0;
    logic [7:0] H_WDATA = 8'h00;
    logic       P_REQ = 1'b0;
    logic [3:0] P_ADDR = 4'h0;
    logic [7:0] P_DATA = 8'h00;
    logic [7:0] PSG_DO = 8'h00;
    logic       H_ACK, P_ACK, PSG_BDIR, PSG_BC, BUSY;
    logic [7:0] H_RDATA, PSG_DI;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] bus;
        logic [7:0] di;
        logic       hack;
        logic       pack;
        logic       busy;
    } obs_t;

    typedef struct {
        bit         player;
        bit         rnw;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] do_val;
        logic [7:0] e_addr_di;
        logic [1:0] e_op_bus;
        logic [7:0] e_op_di;
        logic [7:0] e_rdata;
    } vec_t;

    ym2149_bus_ctrl #(.GAP_CYCLES(GAP)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .H_REQ(H_REQ), .H_RNW(H_RNW), .H_ADDR(H_ADDR), .H_WDATA(H_WDATA),
        .H_ACK(H_ACK), .H_RDATA(H_RDATA),
        .P_REQ(P_REQ), .P_ADDR(P_ADDR), .P_DATA(P_DATA), .P_ACK(P_ACK),
        .PSG_BDIR(PSG_BDIR), .PSG_BC(PSG_BC), .PSG_DI(PSG_DI), .PSG_DO(PSG_DO),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.bus  = {PSG_BDIR, PSG_BC};
        o.di   = PSG_DI;
        o.hack = H_ACK;
        o.pack = P_ACK;
        o.busy = BUSY;
        return o;
    endfunction

    function automatic obs_t mk(logic [1:0] bus, logic [7:0] di, logic hack, logic pack, logic busy);
        obs_t o;
        o.bus = bus; o.di = di; o.hack = hack; o.pack = pack; o.busy = busy;
        return o;
    endfunction

    task automatic chk_obs(input string name, input obs_t exp);
        obs_t act;
        act = observe();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got bus=%b di=%h hack=%b pack=%b busy=%b, want bus=%b di=%h hack=%b pack=%b busy=%b",
                     name, act.bus, act.di, act.hack, act.pack, act.busy,
                     exp.bus, exp.di, exp.hack, exp.pack, exp.busy);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] do_at(input int c);
        logic [31:0] x;
        x = (c * 37) ^ (c >> 3) ^ 32'h5A;
        return x[7:0];
    endfunction

    task automatic do_reset();
        H_REQ = 1'b0;
        P_REQ = 1'b0;
        RESET_N = 1'b0;
        #1;
        chk_obs("reset_outputs", mk(BUS_IDLE, 8'h00, 1'b0, 1'b0, 1'b0));
        chk_val("reset_rdata", H_RDATA, 0);
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    // One isolated transaction, request raised in the current (idle) cycle.
    task automatic run_txn(input vec_t v, input bit skip, input string name);
        H_RNW  = v.rnw;
        PSG_DO = v.do_val;
        if (v.player) begin
            P_ADDR = v.addr; P_DATA = v.data; P_REQ = 1'b1;
        end else begin
            H_ADDR = v.addr; H_WDATA = v.data; H_REQ = 1'b1;
        end
        tick();
        if (!skip) begin
            chk_obs({name, "_addr"}, mk(BUS_ADDR, v.e_addr_di, 1'b0, 1'b0, 1'b1));
            tick();
        end
        chk_obs({name, "_op"}, mk(v.e_op_bus, v.e_op_di, 1'b0, 1'b0, 1'b1));
        tick();
        chk_obs({name, "_ack"}, mk(BUS_IDLE, 8'h00, !v.player, v.player, 1'b1));
        chk_val({name, "_rdata"}, H_RDATA, v.e_rdata);
        for (int i = 1; i <= GAP; i++) begin
            tick();
            if (i == 1) begin
                H_REQ = 1'b0;
                P_REQ = 1'b0;
            end
            chk_obs({name, "_gap"}, mk(BUS_IDLE, 8'h00, 1'b0, 1'b0, i < GAP));
        end
    endtask

    // reference model state for the random phase
    obs_t       sched [64];
    logic       rd_set [64];
    logic [7:0] rd_val [64];
    int         m_free;
    bit         m_last;
    bit         m_cv;
    logic [3:0] m_ca;
    logic [7:0] m_rdata;
    bit         h_pend, h_gnt, p_pend, p_gnt;
    int         h_ack_at, p_ack_at;

    vec_t tbl [7];
    vec_t vc;
    int   order[$];
    int   both_acks, wr1, addr2, idle_n, busy_idle_n, p_acks, rst_acks;
    logic [7:0] wr1_di, addr2_di;
    bit   h_rearm, p_rearm, saw_addr, saw_wr;
    obs_t o;

    initial begin
        tbl[0] = '{0, 0, 4'h8,        8'h0F, 8'hEE, 8'h08, BUS_WRITE, 8'h0F, 8'h00};
        tbl[1] = '{0, 1, R_MIXER,     8'h00, 8'h3E, 8'h07, BUS_READ,  8'h00, 8'h3E};
        tbl[2] = '{1, 0, 4'h0,        8'h11, 8'h99, 8'h00, BUS_WRITE, 8'h11, 8'h3E};
        tbl[3] = '{1, 0, 4'h1,        8'h02, 8'h44, 8'h01, BUS_WRITE, 8'h02, 8'h3E};
        tbl[4] = '{1, 1, R_IOA,       8'hA5, 8'h55, 8'h0E, BUS_WRITE, 8'hA5, 8'h3E};
        tbl[5] = '{0, 1, R_IOB,       8'h00, 8'hC3, 8'h0F, BUS_READ,  8'h00, 8'hC3};
        tbl[6] = '{0, 0, R_ENV_SHAPE, 8'h0A, 8'h81, 8'h0D, BUS_WRITE, 8'h0A, 8'hC3};

        tick();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i], 1'b0, $sformatf("vec%0d", i));
        end

        // contention: both held, each re-raises right after its ACK
        do_reset();
        H_RNW = 1'b0; H_ADDR = 4'h1; H_WDATA = 8'h10;
        P_ADDR = 4'h2; P_DATA = 8'h20;
        H_REQ = 1'b1; P_REQ = 1'b1;
        h_rearm = 1'b0; p_rearm = 1'b0; both_acks = 0;
        order.delete();
        for (int c = 0; c < 80 && order.size() < 4; c++) begin
            tick();
            if (h_rearm) begin H_REQ = 1'b1; h_rearm = 1'b0; end
            if (p_rearm) begin P_REQ = 1'b1; p_rearm = 1'b0; end
            if (H_ACK && P_ACK) both_acks++;
            if (H_ACK) begin order.push_back(0); H_REQ = 1'b0; h_rearm = 1'b1; end
            if (P_ACK) begin order.push_back(1); P_REQ = 1'b0; p_rearm = 1'b1; end
        end
        H_REQ = 1'b0; P_REQ = 1'b0;
        chk_val("contention_count", order.size(), 4);
        chk_val("contention_dual_ack", both_acks, 0);
        for (int i = 0; i < 4; i++) begin
            chk_val($sformatf("contention_order%0d", i), (i < order.size()) ? order[i] : 9, i % 2);
        end

        // back-to-back player writes R0=0x11 then R1=0x02
        do_reset();
        P_ADDR = 4'h0; P_DATA = 8'h11; P_REQ = 1'b1;
        wr1 = -1; addr2 = -1; idle_n = 0; busy_idle_n = 0; p_acks = 0; p_rearm = 1'b0;
        wr1_di = 8'h00; addr2_di = 8'h00;
        for (int c = 0; c < 40; c++) begin
            tick();
            o = observe();
            if (p_rearm) begin P_ADDR = 4'h1; P_DATA = 8'h02; P_REQ = 1'b1; p_rearm = 1'b0; end
            if (o.pack) begin
                p_acks++;
                P_REQ = 1'b0;
                if (p_acks == 1) p_rearm = 1'b1;
            end
            if (wr1 < 0 && o.bus == BUS_WRITE) begin
                wr1 = c; wr1_di = o.di;
            end else if (wr1 >= 0 && addr2 < 0) begin
                if (o.bus == BUS_ADDR) begin
                    addr2 = c; addr2_di = o.di;
                end else if (o.bus == BUS_IDLE) begin
                    idle_n++;
                    if (o.busy) busy_idle_n++;
                end
            end
        end
        chk_val("b2b_wr1_data", wr1_di, 8'h11);
        chk_val("b2b_addr2_data", addr2_di, 8'h01);
        chk_val("b2b_gap_busy_cycles", busy_idle_n, GAP);
        chk_val("b2b_inactive_cycles", idle_n, GAP + 1);
        chk_val("b2b_acks", p_acks, 2);

        // reset asserted during WR
        do_reset();
        P_ADDR = 4'h5; P_DATA = 8'h77; P_REQ = 1'b1;
        tick();
        tick();
        chk_obs("rst_wr_before", mk(BUS_WRITE, 8'h77, 1'b0, 1'b0, 1'b1));
        RESET_N = 1'b0;
        #1;
        chk_obs("rst_during", mk(BUS_IDLE, 8'h00, 1'b0, 1'b0, 1'b0));
        tick();
        chk_obs("rst_hold", mk(BUS_IDLE, 8'h00, 1'b0, 1'b0, 1'b0));
        RESET_N = 1'b1;
        rst_acks = 0; saw_addr = 1'b0; saw_wr = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            o = observe();
            if (o.pack) begin rst_acks++; P_REQ = 1'b0; end
            if (o.bus == BUS_ADDR && o.di == 8'h05) saw_addr = 1'b1;
            if (o.bus == BUS_WRITE && o.di == 8'h77) saw_wr = 1'b1;
        end
        chk_val("rst_reissue_acks", rst_acks, 1);
        chk_val("rst_reissue_addr", saw_addr, 1);
        chk_val("rst_reissue_wr", saw_wr, 1);

        // two host writes to R0: second skips ADDR only with the cache
        do_reset();
        vc = '{0, 0, 4'h0, 8'h55, 8'h00, 8'h00, BUS_WRITE, 8'h55, 8'h00};
        run_txn(vc, 1'b0, "cache_first");
        vc.data = 8'hAA;
        vc.e_op_di = 8'hAA;
        run_txn(vc, CACHE, "cache_second");

        // randomized traffic against a schedule-based model
        do_reset();
        for (int i = 0; i < 64; i++) begin
            sched[i] = '0; rd_set[i] = 1'b0; rd_val[i] = 8'h00;
        end
        m_free = 0; m_last = 1'b1; m_cv = 1'b0; m_ca = 4'h0; m_rdata = 8'h00;
        h_pend = 1'b0; h_gnt = 1'b0; p_pend = 1'b0; p_gnt = 1'b0;
        h_ack_at = -10; p_ack_at = -10;
        for (int c = 0; c < 3000; c++) begin
            int slot;
            tick();
            slot = c % 64;
            PSG_DO = do_at(c);
            if (rd_set[slot]) m_rdata = rd_val[slot];
            chk_obs("random_bus", sched[slot]);
            chk_val("random_rdata", H_RDATA, m_rdata);
            sched[slot] = '0;
            rd_set[slot] = 1'b0;

            if (h_pend) begin
                if (h_gnt && c == h_ack_at + 1) h_pend = 1'b0;
                else if (!h_gnt && $urandom_range(0, 15) == 0) h_pend = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                h_pend = 1'b1; h_gnt = 1'b0;
                H_RNW = 1'($urandom_range(0, 1));
                H_ADDR = 4'($urandom_range(0, 3));
                H_WDATA = 8'($urandom);
            end
            H_REQ = h_pend;
            if (p_pend) begin
                if (p_gnt && c == p_ack_at + 1) p_pend = 1'b0;
                else if (!p_gnt && $urandom_range(0, 15) == 0) p_pend = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                p_pend = 1'b1; p_gnt = 1'b0;
                P_ADDR = 4'($urandom_range(0, 3));
                P_DATA = 8'($urandom);
            end
            P_REQ = p_pend;

            if (c >= m_free && (H_REQ || P_REQ)) begin
                bit w, rn;
                logic [3:0] a;
                logic [7:0] d;
                int t;
                w = (H_REQ && P_REQ) ? !m_last : P_REQ;
                m_last = w;
                a  = w ? P_ADDR : H_ADDR;
                d  = w ? P_DATA : H_WDATA;
                rn = w ? 1'b0 : H_RNW;
                t  = c + 1;
                if (!(CACHE && m_cv && a == m_ca)) begin
                    sched[t % 64].bus = BUS_ADDR;
                    sched[t % 64].di  = {4'h0, a};
                    m_cv = 1'b1;
                    m_ca = a;
                    t++;
                end
                sched[t % 64].bus = rn ? BUS_READ : BUS_WRITE;
                sched[t % 64].di  = rn ? 8'h00 : d;
                if (rn) begin
                    rd_set[(t + 1) % 64] = 1'b1;
                    rd_val[(t + 1) % 64] = do_at(t);
                end
                t++;
                sched[t % 64].hack = !w;
                sched[t % 64].pack = w;
                for (int k = c + 1; k < t + GAP; k++) sched[k % 64].busy = 1'b1;
                m_free = t + GAP;
                if (w) begin p_gnt = 1'b1; p_ack_at = t; end
                else   begin h_gnt = 1'b1; h_ack_at = t; end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
